// File: rtl/nibble_mem_responder_if.sv
// CPU nibble bus plus program-load stream and status seen by the memory responder.
// master = CPU/loader side, slave = responder.
interface nibble_mem_responder_if;
    logic [11:0] bus_addr;
    logic        bus_wr;
    logic [3:0]  bus_data_in;
    logic [3:0]  bus_data_out;
    logic        bus_data_oe;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_hold;
    logic        load_ovf;

    modport master (
        output bus_addr, bus_wr, bus_data_in, load_start, load_valid, load_data, load_last,
        input  bus_data_out, bus_data_oe, load_ready, cpu_hold, load_ovf
    );

    modport slave (
        input  bus_addr, bus_wr, bus_data_in, load_start, load_valid, load_data, load_last,
        output bus_data_out, bus_data_oe, load_ready, cpu_hold, load_ovf
    );
endinterface

// File: rtl/nibble_mem_responder.sv
// Nibble RAM responder with byte-stream program loader; reads are combinational (0 cycles),
// loader accepts one byte per 2 cycles via load_ready and holds the CPU in reset until done.
module nibble_mem_responder #(
    parameter int         AW       = 8,
    parameter logic [3:0] OOR_DATA = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    nibble_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {WAIT, LOAD_LO, LOAD_HI, RUN} state_t;

    state_t      state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [3:0]  hi_q, hi_d;
    logic        last_q, last_d;
    logic        ovf_q, ovf_d;
    logic        hold_q, hold_d;

    logic [3:0]    mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [3:0]    mem_wdata;

    logic ptr_in_range;
    logic addr_in_range;

    // The pointer has one extra bit so it can park at DEPTH instead of wrapping.
    assign ptr_in_range  = !ptr_q[AW];
    assign addr_in_range = (bus.bus_addr < 12'(DEPTH));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hi_d      = hi_q;
        last_d    = last_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[AW-1:0];
        mem_wdata = bus.load_data[3:0];

        case (state_q)
            WAIT: begin
                if (bus.load_start) begin
                    state_d = LOAD_LO;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD_LO: begin
                if (bus.load_valid) begin
                    hi_d    = bus.load_data[7:4];
                    last_d  = bus.load_last;
                    state_d = LOAD_HI;
                    if (ptr_in_range) mem_we = 1'b1;
                    else              ovf_d  = 1'b1;
                end
            end
            LOAD_HI: begin
                // ptr is always even, so ptr+1 is in range exactly when ptr is.
                mem_waddr = ptr_q[AW-1:0] + AW'(1);
                mem_wdata = hi_q;
                if (ptr_in_range) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + (AW+1)'(2);
                end else begin
                    ovf_d = 1'b1;
                end
                state_d = last_q ? RUN : LOAD_LO;
            end
            RUN: begin
                // CPU write data may settle late, so every write edge rewrites the cell.
                if (bus.bus_wr && addr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.bus_addr[AW-1:0];
                    mem_wdata = bus.bus_data_in;
                end
                if (bus.load_start) begin
                    state_d = LOAD_LO;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = WAIT;
        endcase

        hold_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT;
            ptr_q   <= '0;
            hi_q    <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    // RAM is not cleared by reset; a write pending in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        bus.bus_data_out = 4'h0;
        bus.bus_data_oe  = 1'b0;
        if (state_q == RUN) begin
            bus.bus_data_oe  = !bus.bus_wr;
            bus.bus_data_out = addr_in_range ? mem_q[bus.bus_addr[AW-1:0]] : OOR_DATA;
        end
    end

    assign bus.load_ready = (state_q == LOAD_LO);
    assign bus.cpu_hold   = hold_q;
    assign bus.load_ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_mem_responder.sv
// Directed bench for nibble_mem_responder: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_nibble_mem_responder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nibble_mem_responder_if bus_if ();

    nibble_mem_responder #(.AW(8), .OOR_DATA(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic [3:0] d;
        logic       oe;
        logic       hold;
        logic       rdy;
        logic       ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    failures = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            string      nm;
            logic [7:0] act;
            logic [7:0] want;
            e    = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = {bus_if.bus_data_out, bus_if.bus_data_oe, bus_if.cpu_hold,
                    bus_if.load_ready, bus_if.load_ovf};
            want = {e.d, e.oe, e.hold, e.rdy, e.ovf};
            tests++;
            if (act !== want) begin
                failures++;
                $display("FAIL %s: data/oe/hold/rdy/ovf got %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b",
                         nm, act[7:4], act[3], act[2], act[1], act[0],
                         want[7:4], want[3], want[2], want[1], want[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the current cycle, then advance one clock.
    task automatic chk(input string nm, input logic [3:0] d, input logic oe,
                       input logic hold, input logic rdy, input logic ovf);
        exp_t e;
        e.d = d; e.oe = oe; e.hold = hold; e.rdy = rdy; e.ovf = ovf;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
    endtask

    function automatic logic [7:0] big_byte(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b[3:0], b[7:4]} ^ 8'hC3;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus_if.bus_addr     = '0;
        bus_if.bus_wr       = 1'b0;
        bus_if.bus_data_in  = '0;
        bus_if.load_start   = 1'b0;
        bus_if.load_valid   = 1'b0;
        bus_if.load_data    = '0;
        bus_if.load_last    = 1'b0;
        tick(); tick();
        chk("reset_state", 4'h0, 0, 1, 0, 0);
        reset = 1'b0;
        tick();

        // Two-byte load with load_valid held high throughout.
        bus_if.load_start = 1'b1; tick(); bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b1; bus_if.load_data = 8'h21; bus_if.load_last = 1'b0;
        chk("load_lo0", 4'h0, 0, 1, 1, 0);
        bus_if.load_data = 8'h43; bus_if.load_last = 1'b1;
        chk("load_hi0", 4'h0, 0, 1, 0, 0);
        chk("load_lo1", 4'h0, 0, 1, 1, 0);
        bus_if.load_valid = 1'b0; bus_if.load_last = 1'b0;
        chk("load_hi1", 4'h0, 0, 1, 0, 0);

        bus_if.bus_addr = 12'h000; chk("rd_000", 4'h1, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h001; chk("rd_001", 4'h2, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h003; chk("rd_003", 4'h4, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h002; chk("rd_002", 4'h3, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h100; chk("rd_oor_100", 4'hF, 1, 0, 0, 0);

        // Write held two edges; second value must win.
        bus_if.bus_addr = 12'h005; bus_if.bus_wr = 1'b1; bus_if.bus_data_in = 4'h0;
        tick();
        bus_if.bus_data_in = 4'hA;
        chk("wr_005_mid", 4'h0, 0, 0, 0, 0);
        bus_if.bus_wr = 1'b0;
        chk("rd_005", 4'hA, 1, 0, 0, 0);

        bus_if.bus_addr = 12'h800; bus_if.bus_wr = 1'b1; bus_if.bus_data_in = 4'h7;
        tick();
        bus_if.bus_wr = 1'b0; bus_if.bus_addr = 12'h000;
        chk("oor_wr_dropped", 4'h1, 1, 0, 0, 0);

        // Overflowing load: 130 bytes into 256 nibbles.
        bus_if.load_start = 1'b1; tick(); bus_if.load_start = 1'b0;
        for (int i = 0; i < 130; i++) begin
            int n;
            bus_if.load_valid = 1'b1;
            bus_if.load_data  = big_byte(i);
            bus_if.load_last  = (i == 129);
            n = 0;
            while (!bus_if.load_ready) begin
                tick();
                n++;
                if (n > 8) begin
                    $display("FAIL load_ready_timeout: byte %0d never accepted", i);
                    $fatal(1, "timeout");
                end
            end
            tick();
        end
        bus_if.load_valid = 1'b0; bus_if.load_last = 1'b0;
        tick();
        bus_if.bus_addr = 12'h000; chk("ovf_rd_000", 4'h3, 1, 0, 0, 1);
        bus_if.bus_addr = 12'h001; chk("ovf_rd_001", 4'hC, 1, 0, 0, 1);
        bus_if.bus_addr = 12'h002; chk("ovf_rd_002", 4'h3, 1, 0, 0, 1);
        bus_if.bus_addr = 12'h007; chk("ovf_rd_007", 4'hF, 1, 0, 0, 1);
        bus_if.bus_addr = 12'h0FF; chk("ovf_rd_0ff", 4'h3, 1, 0, 0, 1);

        bus_if.load_start = 1'b1; tick(); bus_if.load_start = 1'b0;
        chk("ovf_cleared", 4'h0, 0, 1, 1, 0);

        // Abort a load with reset while in LOAD_HI.
        bus_if.load_valid = 1'b1; bus_if.load_data = 8'h65;
        tick();
        bus_if.load_data = 8'h87;
        tick();
        tick();
        reset = 1'b1; bus_if.load_valid = 1'b0;
        tick();
        chk("reset_in_hi", 4'h0, 0, 1, 0, 0);
        reset = 1'b0;
        bus_if.load_valid = 1'b1; bus_if.load_data = 8'hEE;
        chk("wait_ignores_valid", 4'h0, 0, 1, 0, 0);
        bus_if.load_valid = 1'b0;

        bus_if.load_start = 1'b1; tick(); bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b1; bus_if.load_data = 8'hCB; bus_if.load_last = 1'b1;
        tick();
        bus_if.load_valid = 1'b0; bus_if.load_last = 1'b0;
        tick();
        bus_if.bus_addr = 12'h002; chk("retained_002", 4'h7, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h000; chk("reload_000", 4'hB, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h001; chk("reload_001", 4'hC, 1, 0, 0, 0);

        // CPU write and load_start on the same edge.
        bus_if.bus_addr = 12'h009; bus_if.bus_wr = 1'b1; bus_if.bus_data_in = 4'h6;
        bus_if.load_start = 1'b1;
        tick();
        bus_if.bus_wr = 1'b0; bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b1; bus_if.load_data = 8'h10; bus_if.load_last = 1'b1;
        chk("start_with_wr", 4'h0, 0, 1, 1, 0);
        bus_if.load_valid = 1'b0; bus_if.load_last = 1'b0;
        tick();
        bus_if.bus_addr = 12'h009; chk("wr_with_start_009", 4'h6, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h000; chk("last_load_000", 4'h0, 1, 0, 0, 0);
        bus_if.bus_addr = 12'h001; chk("last_load_001", 4'h1, 1, 0, 0, 0);

        tick(); tick();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
            $fatal(1, "drain");
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/nibble_mem_responder.md
Name: nibble_mem_responder

Overview:
- Memory-side responder for the CPU's 4-bit data / 12-bit address nibble bus.
- Serves instruction fetches and LD reads from an on-chip nibble RAM, and commits STO writes.
- Includes a byte-stream program loader that fills the RAM while holding the CPU in reset, then releases it.
- Sits between the CPU core and the chip-level program-load pins.

Parameters:
- AW, 8, RAM address width; depth = 2**AW nibbles, mapped at bus addresses 0 .. 2**AW-1.
- OOR_DATA, 4'hF, value returned on reads outside the RAM (NOP opcode).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bus_addr  in  12  address from CPU
- bus_wr  in  1  1 = CPU driving write data this cycle
- bus_data_in  in  4  write data from CPU
- bus_data_out  out  4  read data to CPU
- bus_data_oe  out  1  responder drives bus_data (pad-level tristate control)
- load_start  in  1  pulse: begin program load
- load_valid  in  1  load_data valid
- load_data  in  8  program byte; [3:0] = even nibble, [7:4] = odd nibble
- load_last  in  1  qualifies final byte of the stream
- load_ready  out  1  loader accepts a byte this cycle
- cpu_hold  out  1  drive to CPU reset; 1 while no valid program is loaded
- load_ovf  out  1  sticky: bytes were dropped because the RAM was full

Behaviour:
- States: WAIT, LOAD_LO, LOAD_HI, RUN.
- Reset: state = WAIT, cpu_hold = 1, load_ready = 0, load_ovf = 0, load pointer = 0, bus_data_oe = 0, bus_data_out = 0.
- RAM contents are not cleared by reset.
- WAIT: cpu_hold = 1. On load_start, go to LOAD_LO, clear the pointer, clear load_ovf.
- LOAD_LO: load_ready = 1, cpu_hold = 1. On load_valid & load_ready:
  - write load_data[3:0] to mem[ptr];
  - latch load_data[7:4] and load_last;
  - go to LOAD_HI.
- LOAD_HI: load_ready = 0. Write the latched high nibble to mem[ptr+1], then ptr += 2.
  - If the latched last flag is set, go to RUN.
  - Otherwise return to LOAD_LO.
  - Net throughput: 1 byte per 2 cycles.
- Pointer overflow: a nibble write with ptr >= 2**AW is dropped and sets load_ovf. The pointer saturates and does not wrap.
- load_start is ignored in LOAD_LO and LOAD_HI. In RUN it re-enters LOAD_LO, and cpu_hold rises in that same cycle via registered output, i.e. visible the next cycle.
- RUN: cpu_hold = 0 (registered; falls the cycle after the LOAD_HI write of the last byte).
- Read path, RUN only, combinational:
  - bus_data_out = mem[bus_addr] if bus_addr < 2**AW, else OOR_DATA.
  - bus_data_oe = !bus_wr.
  - Zero added latency: the address presented at edge N must yield valid data before edge N+1, where the CPU samples it.
- Write path, RUN only: on every edge with bus_wr = 1 and bus_addr in range, mem[bus_addr] <= bus_data_in. The last such write wins, because CPU write data may settle one cycle after bus_wr rises.
  - Out-of-range writes are dropped silently.
- Outside RUN: bus_data_oe = 0, bus_data_out = 0, and CPU writes are ignored.
- Simultaneous load_start and bus_wr in RUN: the write commits; the load begins in the same edge.
- Reset mid-load: the load aborts and the state returns to WAIT. Partially written RAM is retained; cpu_hold stays 1.
- load_valid with load_ready = 0: no effect. The source holds the byte; no data is lost.

Test Plan:
- Reset, then check outputs before any load → cpu_hold = 1, load_ready = 0, bus_data_oe = 0, load_ovf = 0.
- load_start, then bytes 0x21, 0x43 (the second with load_last), load_valid held continuously → load_ready alternates 1/0.
  - Addresses 0..3 read 1, 2, 3, 4.
  - cpu_hold falls 1 cycle after the final LOAD_HI.
- In RUN, bus_addr = 0x002, bus_wr = 0 → bus_data_out = 3 in the same cycle, bus_data_oe = 1.
- In RUN, bus_addr = 0x100 (AW = 8) → bus_data_out = 0xF.
- Write to 0x005 with bus_wr high for 2 edges and bus_data_in 0x0 then 0xA → a read of 0x005 returns 0xA.
  - A write to 0x800 is dropped.
- Load 130 bytes with AW = 8 → load_ovf = 1.
  - Addresses 0..255 hold the first 128 bytes; the RAM wraps nowhere.
  - A subsequent load_start clears load_ovf.
- Assert reset in LOAD_HI mid-stream → state returns to WAIT, cpu_hold = 1, load_ready = 0.
  - The earlier nibbles remain readable after a fresh load_start/load_last sequence.
